// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcode constants, operand classifier, fetch states.
// Imported by fetch, control and execute.
package isa_pkg;

  localparam int WORD_W = 16;

  localparam logic [WORD_W-1:0] OP_LDAC  = 16'd7;
  localparam logic [WORD_W-1:0] OP_STAC  = 16'd11;
  localparam logic [WORD_W-1:0] OP_MVAC  = 16'd15;
  localparam logic [WORD_W-1:0] OP_MVR   = 16'd16;
  localparam logic [WORD_W-1:0] OP_ADD   = 16'd17;
  localparam logic [WORD_W-1:0] OP_ADDM  = 16'd19;
  localparam logic [WORD_W-1:0] OP_INAC  = 16'd23;
  localparam logic [WORD_W-1:0] OP_SUB   = 16'd24;
  localparam logic [WORD_W-1:0] OP_MUL   = 16'd26;
  localparam logic [WORD_W-1:0] OP_MULM  = 16'd28;
  localparam logic [WORD_W-1:0] OP_CLAC  = 16'd32;
  localparam logic [WORD_W-1:0] OP_JUMP  = 16'd33;
  localparam logic [WORD_W-1:0] OP_JPNZ  = 16'd35;
  localparam logic [WORD_W-1:0] OP_ENDOP = 16'd40;
  localparam logic [WORD_W-1:0] OP_NOP   = 16'd41;

  typedef enum logic [2:0] {
    S_REQ,
    S_OPC,
    S_OPND,
    S_VALID,
    S_HALT
  } fetch_state_t;

  function automatic logic has_operand(input logic [WORD_W-1:0] op);
    return op inside {OP_LDAC, OP_STAC, OP_ADDM,
                      OP_MULM, OP_JUMP, OP_JPNZ};
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, hides the one-cycle IRAM read latency and
// assembles opcode/operand pairs for a valid/ready consumer.
module instr_fetch
  import isa_pkg::*;
#(
  parameter int          ADDR_W   = 16,
  parameter int          DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] iram_addr,
  input  logic [DATA_W-1:0] iram_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_opcode,
  output logic [DATA_W-1:0] instr_operand,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic              is_end;

  assign iram_addr = pc;
  assign is_end    = (instr_opcode == DATA_W'(OP_ENDOP));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_REQ;
      pc            <= RESET_PC;
      instr_pc      <= RESET_PC;
      instr_valid   <= 1'b0;
      instr_opcode  <= '0;
      instr_operand <= '0;
      halted        <= 1'b0;
    end else if (redirect_valid && state != S_HALT) begin
      // Redirect wins over a same-cycle handshake and drops partial work.
      pc          <= redirect_pc;
      state       <= S_REQ;
      instr_valid <= 1'b0;
    end else begin
      unique case (state)
        S_REQ: begin
          instr_pc <= pc;
          pc       <= pc + ADDR_W'(1);
          state    <= S_OPC;
        end
        S_OPC: begin
          instr_opcode <= iram_data;
          if (has_operand(iram_data)) begin
            pc    <= pc + ADDR_W'(1);
            state <= S_OPND;
          end else begin
            instr_operand <= '0;
            instr_valid   <= 1'b1;
            state         <= S_VALID;
          end
        end
        S_OPND: begin
          instr_operand <= iram_data;
          instr_valid   <= 1'b1;
          state         <= S_VALID;
        end
        S_VALID: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            halted      <= is_end;
            state       <= is_end ? S_HALT : S_REQ;
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_REQ;
        end
      endcase
    end
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage sitting directly upstream of the instruction RAM and downstream-facing toward the control/execute unit. Holds the program counter and drives the IRAM address. Absorbs the IRAM's one-cycle registered read latency and assembles one- or two-word instructions (opcode plus optional operand word). Delivers each instruction over a valid/ready handshake, and accepts PC redirects from execute for JUMP and JPNZ.

## Interface
- `ADDR_W`, 16, PC and IRAM address width
- `DATA_W`, 16, instruction word width
- `RESET_PC`, 0, PC value after reset
- `clk`  in  1  clock; all state changes on its rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `iram_addr`  out  ADDR_W  IRAM read address, combinationally equal to the PC register
- `iram_data`  in  DATA_W  IRAM registered read data, valid one cycle after the address
- `instr_valid`  out  1  instruction fields below are valid
- `instr_ready`  in  1  consumer accepts the instruction this cycle
- `instr_opcode`  out  DATA_W  opcode word
- `instr_operand`  out  DATA_W  operand word; 0 for single-word opcodes
- `instr_pc`  out  ADDR_W  address of the opcode word
- `redirect_valid`  in  1  load a new PC and flush the fetch in progress
- `redirect_pc`  in  ADDR_W  target PC
- `halted`  out  1  ENDOP accepted; fetch stopped

## Operation
- **Two-word opcodes:** LDAC=7, STAC=11, ADDM=19, MULM=28, JUMP=33, JPNZ=35.
- **Single-word opcodes:** every other value, including MVAC=15, MVR=16, ADD=17, INAC=23, SUB=24, MUL=26, CLAC=32, NOP=41, ENDOP=40 and undefined codes.
- **States:** REQ, OPC, OPND, VALID, HALT. Reset state is REQ.
- **REQ:** iram_addr=pc. Next edge: instr_pc<=pc, pc<=pc+1, go OPC.
- **OPC:** iram_data = ram[instr_pc]. Next edge: opcode<=iram_data.
  - Two-word: pc<=pc+1, go OPND. The operand address was already presented during OPC.
  - Single-word: operand<=0, go VALID.
- **OPND:** next edge: operand<=iram_data, go VALID.
- **VALID:** instr_valid=1. Fields stay stable until the handshake completes (instr_valid & instr_ready at an edge).
  - On handshake with opcode ENDOP: go HALT.
  - On handshake with any other opcode: go REQ.
- **HALT:** halted=1, instr_valid=0, pc frozen. Only reset leaves HALT. redirect_valid is ignored here.
- **Redirect:** redirect_valid=1 in REQ, OPC, OPND or VALID.
  - pc<=redirect_pc, go REQ, discard any partially assembled instruction.
  - Takes priority over a simultaneous handshake. The presented instruction counts as consumed only if instr_ready was also high.
- **Arithmetic:** pc increments are modulo 2^ADDR_W, so 0xFFFF+1 = 0x0000. An operand fetched across the wrap is read from address 0.
- **Reset mid-operation:** rst_n low at any time forces the reset values immediately, regardless of clk.

## Timing
- **Reset values:**
  - pc = iram_addr = instr_pc = RESET_PC
  - instr_valid = 0, halted = 0
  - instr_opcode = 0, instr_operand = 0
  - state = REQ
- **Latency after rst_n release:**
  - Single-word: instr_valid high after the 2nd rising edge.
  - Two-word: instr_valid high after the 3rd rising edge.
- **Throughput with instr_ready held high:**
  - Single-word: 3 cycles per instruction.
  - Two-word: 4 cycles per instruction.
- **Redirect:** instr_valid drops the cycle after the redirect edge. iram_addr = redirect_pc in the cycle following the redirect.
- **Outputs:** all are registered, except iram_addr, which is the pc register itself.
- **Ready path:** no combinational path from instr_ready to any output.

## Structure
- **Shared package `isa_pkg`:**
  - opcode constants listed above
  - `has_operand(opcode)` function
  - fetch state enum
  - The execute and control blocks import the same package.
- **Sub-module:** none. The opcode classifier is a package function, not a separate module.

## Test plan
- **Program load:** memory holds LDAC,130,MVAC,LDAC,135,MUL,STAC,65400,ENDOP; instr_ready=1.
  - Delivers (7,130,pc0), (15,0,pc2), (7,135,pc3), (26,0,pc5), (11,65400,pc6), (40,0,pc8).
  - halted=1 afterwards; iram_addr frozen at 9.
- **Backpressure:** hold instr_ready=0 for 5 cycles on LDAC,130. Fields stay (7,130,0) and stable; pc stays 2; no further IRAM sequencing.
- **Redirect mid-operand:** assert redirect_valid with redirect_pc=20 while in OPND of STAC at pc 6. No instruction from pc 6 is delivered; the next delivered instr_pc is 20.
- **Redirect plus handshake:** same-cycle redirect and handshake on JPNZ,5. JPNZ counts as consumed exactly once; the next instr_pc is 5.
- **Wrap:** RESET_PC=0xFFFF with ram[0xFFFF]=LDAC and ram[0]=99. Delivers (7,99,0xFFFF); the next fetch starts at pc 1.
- **Async reset:** pulse rst_n low between clock edges while in VALID. instr_valid=0 and iram_addr=RESET_PC immediately; fetch restarts cleanly after release.
